uart_rx_param: RTL and testbench

Parametrised UART receiver and the next generation of the team's fixed 8N1 receiver. Adds configurable data width, parity and stop bits, 16x oversampled mid-bit sampling, false-start rejection, error flags and a valid/ready output handshake. Sits between the board RX pin and the CPU load/debug path; it feeds the instruction/data loader.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_baud_tick.sv | 49 ++++
 rtl/uart_rx_param.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared receiver state encoding, parity modes and baud divider maths. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int uart_div(input int clk, input int baud, input int os);
        return clk / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_baud_tick                                                       |
// | Oversampling tick generator with a per-bit tick counter.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_baud_tick #(
    parameter int DIV        = 54,
    parameter int OVERSAMPLE = 16,
    parameter int TICK_W     = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clear,
    output logic              o_tick,
    output logic [TICK_W-1:0] o_tick_cnt
);

    localparam int c_DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_DIV_W-1:0] r_div;
    logic [TICK_W-1:0]  r_tick_cnt;
    logic               w_tick;

    assign w_tick     = !i_clear && (r_div == c_DIV_W'(DIV - 1));
    assign o_tick     = w_tick;
    assign o_tick_cnt = r_tick_cnt;

    // o_tick_cnt is the number of ticks already seen in the current bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
        end else if (i_clear) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_div <= '0;
            if (r_tick_cnt == TICK_W'(OVERSAMPLE - 1))
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + 1'b1;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_param                                                        |
// | Parametrised oversampled UART receiver with valid/ready output.      |
// | Optional: UART_RX_MAJORITY_EN enables 2-of-3 majority bit sampling.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun
);

    localparam int   c_DIV    = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int   c_TICK_W = $clog2(OVERSAMPLE);
    localparam logic c_ODD    = (PARITY == PAR_ODD);

    uart_state_t           r_state, w_next;
    logic [1:0]            r_sync;
    logic                  w_rxs;
    logic                  w_tick;
    logic [c_TICK_W-1:0]   w_tick_cnt;
    logic                  w_strobe;
    logic                  w_bit;
    logic                  w_clear, w_shift, w_par_cap, w_stop_ok, w_frame_fail, w_frame_done;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_par_rx;
    logic [3:0]            r_bit_cnt;
    logic [1:0]            r_stop_cnt;
    logic                  r_done, r_frame_err;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid, r_perr, r_overrun;
    logic                  w_par_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sync <= 2'b11;
        else          r_sync <= {r_sync[0], i_rx};
    end
    assign w_rxs = r_sync[1];

    uart_baud_tick #(
        .DIV        (c_DIV),
        .OVERSAMPLE (OVERSAMPLE),
        .TICK_W     (c_TICK_W)
    ) u_baud_tick (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_clear    (w_clear),
        .o_tick     (w_tick),
        .o_tick_cnt (w_tick_cnt)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_early;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_early <= '0;
        else if (w_tick && w_tick_cnt == c_TICK_W'(OVERSAMPLE/2 - 2))
            r_early[0] <= w_rxs;
        else if (w_tick && w_tick_cnt == c_TICK_W'(OVERSAMPLE/2 - 1))
            r_early[1] <= w_rxs;
    end
    // Decision lands on the third sample, one tick past mid-bit
    assign w_strobe = w_tick && (w_tick_cnt == c_TICK_W'(OVERSAMPLE/2));
    assign w_bit    = (r_early[0] & r_early[1]) | (r_early[0] & w_rxs) | (r_early[1] & w_rxs);
`else
    assign w_strobe = w_tick && (w_tick_cnt == c_TICK_W'(OVERSAMPLE/2 - 1));
    assign w_bit    = w_rxs;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_clear      = 1'b0;
        w_shift      = 1'b0;
        w_par_cap    = 1'b0;
        w_stop_ok    = 1'b0;
        w_frame_fail = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = 1'b1;
                if (!w_rxs) w_next = ST_START;
            end
            ST_START: begin
                if (w_strobe) w_next = w_bit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (w_strobe) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 4'(DATA_BITS - 1))
                        w_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (w_strobe) begin
                    w_par_cap = 1'b1;
                    w_next    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_strobe) begin
                    if (!w_bit) begin
                        w_frame_fail = 1'b1;
                        w_next       = ST_WAIT_IDLE;
                    end else begin
                        w_stop_ok = 1'b1;
                        if (r_stop_cnt == 2'(STOP_BITS - 1)) begin
                            w_frame_done = 1'b1;
                            w_next       = ST_IDLE;
                        end
                    end
                end
            end
            ST_WAIT_IDLE: begin
                w_clear = 1'b1;
                if (w_rxs) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift     <= '0;
            r_par_rx    <= 1'b0;
            r_bit_cnt   <= '0;
            r_stop_cnt  <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_done      <= w_frame_done;
            r_frame_err <= w_frame_fail;
            if (r_state == ST_IDLE) begin
                r_bit_cnt  <= '0;
                r_stop_cnt <= '0;
            end else begin
                if (w_shift) begin
                    r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                if (w_stop_ok) r_stop_cnt <= r_stop_cnt + 1'b1;
            end
            if (w_par_cap) r_par_rx <= w_bit;
        end
    end

    assign w_par_err = (PARITY != PAR_NONE) && (r_par_rx != ((^r_shift) ^ c_ODD));

    // A completed frame loads only if the slot is free or being drained this cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_done && (!r_valid || i_ready)) begin
                r_data  <= r_shift;
                r_perr  <= w_par_err;
                r_valid <= 1'b1;
            end else begin
                if (r_done)  r_overrun <= 1'b1;
                if (i_ready) r_valid   <= 1'b0;
            end
        end
    end

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_parity_err = r_perr;
    assign o_frame_err  = r_frame_err;
    assign o_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_param                                                     |
// | Scoreboard bench: 8N1 instance and 7E2 (OVERSAMPLE=10) instance.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_param;

    localparam int A_CLK = 100000000, A_BAUD = 3125000, A_OS = 16;
    localparam int A_DB = 8, A_PAR = 0, A_SB = 1;
    localparam int B_CLK = 100000000, B_BAUD = 2000000, B_OS = 10;
    localparam int B_DB = 7, B_PAR = 2, B_SB = 2;
    localparam int A_BIT = (A_CLK / (A_BAUD * A_OS)) * A_OS;
    localparam int B_BIT = (B_CLK / (B_BAUD * B_OS)) * B_OS;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, rx_a, rx_b, ready;
    logic [A_DB-1:0] a_data;
    logic [B_DB-1:0] b_data;
    logic a_valid, a_perr, a_ferr, a_ovr;
    logic b_valid, b_perr, b_ferr, b_ovr;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;
    int n_tests = 0, n_fail = 0;
    int exp_ferr_a = 0, exp_ferr_b = 0, got_ferr_a = 0, got_ferr_b = 0;
    int exp_ovr_a = 0, exp_ovr_b = 0, got_ovr_a = 0, got_ovr_b = 0;
    int sel, gap;
    logic [8:0] rnd_data;
    logic rnd_pf, rnd_sb;

    always #5 clk = ~clk;

    uart_rx_param #(
        .CLK_FREQ(A_CLK), .BAUD_RATE(A_BAUD), .OVERSAMPLE(A_OS),
        .DATA_BITS(A_DB), .PARITY(A_PAR), .STOP_BITS(A_SB)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_a), .o_data(a_data), .o_valid(a_valid),
        .i_ready(ready), .o_parity_err(a_perr), .o_frame_err(a_ferr), .o_overrun(a_ovr)
    );

    uart_rx_param #(
        .CLK_FREQ(B_CLK), .BAUD_RATE(B_BAUD), .OVERSAMPLE(B_OS),
        .DATA_BITS(B_DB), .PARITY(B_PAR), .STOP_BITS(B_SB)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx_b), .o_data(b_data), .o_valid(b_valid),
        .i_ready(ready), .o_parity_err(b_perr), .o_frame_err(b_ferr), .o_overrun(b_ovr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted word is popped from the scoreboard and compared
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_valid && ready) begin
                n_tests++;
                if (q_a.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_unexpected_valid: actual data=%0h required no word", a_data);
                end else begin
                    n_tests--;
                    e_a = q_a.pop_front();
                    check("a_data", 32'(a_data), 32'(e_a.data));
                    check("a_perr", 32'(a_perr), 32'(e_a.perr));
                end
            end
            if (b_valid && ready) begin
                n_tests++;
                if (q_b.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected_valid: actual data=%0h required no word", b_data);
                end else begin
                    n_tests--;
                    e_b = q_b.pop_front();
                    check("b_data", 32'(b_data), 32'(e_b.data));
                    check("b_perr", 32'(b_perr), 32'(e_b.perr));
                end
            end
            if (a_ferr) got_ferr_a++;
            if (b_ferr) got_ferr_b++;
            if (a_ovr)  got_ovr_a++;
            if (b_ovr)  got_ovr_b++;
        end
    end

    task automatic drive_bits(input int s, input int nbits, input logic [15:0] bits);
        for (int i = 0; i < nbits; i++) begin
            if (s != 0) rx_b = bits[i];
            else        rx_a = bits[i];
            repeat ((s != 0) ? B_BIT : A_BIT) @(negedge clk);
        end
    endtask

    task automatic idle(input int s, input int nclk);
        if (s != 0) rx_b = 1'b1;
        else        rx_a = 1'b1;
        repeat (nclk) @(negedge clk);
    endtask

    // Reference model: frame built from the line format, expected word pushed first
    task automatic send(input int s, input logic [8:0] data, input logic par_flip,
                        input logic stop_bad, input logic expect_it);
        int db  = (s != 0) ? B_DB  : A_DB;
        int par = (s != 0) ? B_PAR : A_PAR;
        int sb  = (s != 0) ? B_SB  : A_SB;
        int bt  = (s != 0) ? B_BIT : A_BIT;
        int n   = 0;
        logic [15:0] f = '0;
        logic [8:0] d;
        logic p;
        exp_t e;
        d = data & ((9'd1 << db) - 9'd1);
        f[n] = 1'b0; n++;
        for (int i = 0; i < db; i++) begin f[n] = d[i]; n++; end
        if (par != 0) begin
            p = (($countones(d) % 2) == 1);
            if (par == 1) p = ~p;
            f[n] = p ^ par_flip; n++;
        end
        for (int i = 0; i < sb; i++) begin
            f[n] = !(stop_bad && i == sb - 1); n++;
        end
        if (stop_bad) begin
            if (s != 0) exp_ferr_b++; else exp_ferr_a++;
        end else if (expect_it) begin
            e.data = d;
            e.perr = (par != 0) ? par_flip : 1'b0;
            if (s != 0) q_b.push_back(e); else q_a.push_back(e);
        end
        drive_bits(s, n, f);
        if (stop_bad) begin
            repeat (2 * bt) @(negedge clk);
            idle(s, bt);
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; ready = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_a_data",  32'(a_data),  0);
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_a_perr",  32'(a_perr),  0);
        check("rst_a_ferr",  32'(a_ferr),  0);
        check("rst_a_ovr",   32'(a_ovr),   0);
        check("rst_b_data",  32'(b_data),  0);
        check("rst_b_valid", 32'(b_valid), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(0, 9'h0A5, 1'b0, 1'b0, 1'b1);
        idle(0, 2 * A_BIT);
        send(0, 9'h055, 1'b0, 1'b1, 1'b1);
        send(0, 9'h012, 1'b0, 1'b0, 1'b1);
        idle(0, A_BIT);
        check("ferr_a_after_break", 32'(got_ferr_a), 32'(exp_ferr_a));

        rx_a = 1'b0; repeat (8) @(negedge clk);
        idle(0, 2 * A_BIT);
        send(0, 9'h03C, 1'b0, 1'b0, 1'b1);
        idle(0, A_BIT);

        send(1, 9'h003, 1'b1, 1'b0, 1'b1);
        send(1, 9'h003, 1'b0, 1'b0, 1'b1);
        rx_b = 1'b0; repeat (10) @(negedge clk);
        idle(1, 2 * B_BIT);
        send(1, 9'h05A, 1'b0, 1'b0, 1'b1);
        idle(1, B_BIT);
        check("a_queue_drained", 32'(q_a.size()), 0);
        check("b_queue_drained", 32'(q_b.size()), 0);

        ready = 1'b0;
        send(0, 9'h011, 1'b0, 1'b0, 1'b1);
        send(0, 9'h022, 1'b0, 1'b0, 1'b0);
        exp_ovr_a++;
        idle(0, 2 * A_BIT);
        check("ovr_hold_valid", 32'(a_valid), 1);
        check("ovr_hold_data",  32'(a_data), 32'h11);
        check("ovr_count",      32'(got_ovr_a), 32'(exp_ovr_a));
        @(posedge clk); #1 ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ovr_valid_drop", 32'(a_valid), 0);

        rx_a = 1'b0;
        repeat (A_BIT) @(negedge clk);
        rx_a = 1'b1;
        repeat (3 * A_BIT + A_BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_a_data",  32'(a_data),  0);
        check("midrst_a_valid", 32'(a_valid), 0);
        check("midrst_a_ferr",  32'(a_ferr),  0);
        check("midrst_a_ovr",   32'(a_ovr),   0);
        rst_n = 1'b1;
        idle(0, 3 * A_BIT);
        send(0, 9'h07E, 1'b0, 1'b0, 1'b1);
        idle(0, A_BIT);

        for (int k = 0; k < 40; k++) begin
            sel      = int'($urandom_range(0, 1));
            rnd_data = 9'($urandom);
            rnd_pf   = (sel != 0) && ($urandom_range(0, 3) == 0);
            rnd_sb   = ($urandom_range(0, 7) == 0);
            send(sel, rnd_data, rnd_pf, rnd_sb, 1'b1);
            gap = int'($urandom_range(0, 2)) * int'($urandom_range(0, 40));
            if (gap > 0) idle(sel, gap);
        end

        idle(0, 3 * B_BIT);
        check("final_a_queue", 32'(q_a.size()), 0);
        check("final_b_queue", 32'(q_b.size()), 0);
        check("final_a_ferr",  32'(got_ferr_a), 32'(exp_ferr_a));
        check("final_b_ferr",  32'(got_ferr_b), 32'(exp_ferr_b));
        check("final_a_ovr",   32'(got_ovr_a),  32'(exp_ovr_a));
        check("final_b_ovr",   32'(got_ovr_b),  32'(exp_ovr_b));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
